// File: rtl/alu_muldiv_unit.sv
// RV32M multiply/divide unit beside the EX-stage ALU, one result bit per cycle.
// Latency: result_valid XLEN+1 cycles after the accept cycle, or 1 cycle for div-by-zero/overflow.
// Backpressure: stall holds the pipeline while an M op is presented and no result is out; flush kills.
module alu_muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start_valid,
  input  logic [1:0]      ALUOp,
  input  logic [6:0]      Funct7,
  input  logic [2:0]      Funct3,
  input  logic [XLEN-1:0] srcA,
  input  logic [XLEN-1:0] srcB,
  input  logic            flush,
  output logic            is_muldiv,
  output logic            busy,
  output logic            stall,
  output logic            result_valid,
  output logic [XLEN-1:0] result
);

  localparam int              CW   = $clog2(XLEN);
  localparam logic [CW-1:0]   LAST = CW'(XLEN - 1);
  localparam logic [XLEN-1:0] SMIN = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t          state, state_nx;
  logic            accept;

  // decode of the presented instruction
  logic            a_sgn, b_sgn, sa, sb, acc_neg, spec;
  logic [XLEN-1:0] mag_a, mag_b, spec_res;

  // latched operation
  logic [2:0]      op_q;
  logic            neg_q;
  logic [XLEN-1:0] opnd_q;   // multiplicand or divisor
  logic [XLEN-1:0] acc_hi;   // product high half or partial remainder
  logic [XLEN-1:0] acc_lo;   // multiplier/product low half or dividend/quotient
  logic [CW-1:0]   cnt;

  // one iteration step
  logic [XLEN:0]   mul_sum;
  logic [XLEN:0]   div_part;
  logic [XLEN:0]   div_diff;
  logic            div_brw, div_ok;
  logic [XLEN-1:0] hi_nx, lo_nx;

  // final result formatting
  logic [2*XLEN-1:0] prod, prod_s;
  logic [XLEN-1:0]   div_raw, div_res, fin_res;

  assign is_muldiv = (ALUOp == 2'b10) && (Funct7 == 7'b0000001);
  assign busy      = (state != IDLE);
  assign stall     = start_valid && is_muldiv && !result_valid;

  // operand signedness, magnitudes and the cases answered without iterating
  always_comb begin
    a_sgn    = 1'b0;
    b_sgn    = 1'b0;
    spec     = 1'b0;
    spec_res = '0;
    case (Funct3)
      3'b000, 3'b001: begin a_sgn = 1'b1; b_sgn = 1'b1; end
      3'b010:         begin a_sgn = 1'b1; b_sgn = 1'b0; end
      3'b100, 3'b110: begin a_sgn = 1'b1; b_sgn = 1'b1; end
      default:        begin a_sgn = 1'b0; b_sgn = 1'b0; end
    endcase
    sa    = a_sgn & srcA[XLEN-1];
    sb    = b_sgn & srcB[XLEN-1];
    mag_a = sa ? -srcA : srcA;
    mag_b = sb ? -srcB : srcB;
    // remainder follows the dividend sign; product and quotient follow sign difference
    acc_neg = (Funct3[2] && Funct3[1]) ? sa : (sa ^ sb);
    if (Funct3[2]) begin
      if (srcB == '0) begin
        spec     = 1'b1;
        spec_res = Funct3[1] ? srcA : '1;
      end else if (!Funct3[0] && srcA == SMIN && srcB == '1) begin
        spec     = 1'b1;
        spec_res = Funct3[1] ? '0 : srcA;
      end
    end
  end

  // next state; flush beats any accept or progress
  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    case (state)
      IDLE: if (start_valid && is_muldiv) begin
              accept   = 1'b1;
              state_nx = spec ? DONE : CALC;
            end
      CALC: if (cnt == LAST) state_nx = DONE;
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (flush) begin
      accept   = 1'b0;
      state_nx = IDLE;
    end
  end

  // state register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // one shift-add or restoring-subtract step, plus sign fix-up of the last step's value
  always_comb begin
    mul_sum  = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd_q} : '0);
    div_part = {acc_hi, acc_lo[XLEN-1]};
    {div_brw, div_diff} = {1'b0, div_part} - {2'b0, opnd_q};
    // bit XLEN of the difference can only be set together with a borrow
    div_ok   = !div_brw && !div_diff[XLEN];
    if (op_q[2]) begin
      hi_nx = div_ok ? div_diff[XLEN-1:0] : div_part[XLEN-1:0];
      lo_nx = {acc_lo[XLEN-2:0], div_ok};
    end else begin
      hi_nx = mul_sum[XLEN:1];
      lo_nx = {mul_sum[0], acc_lo[XLEN-1:1]};
    end
    prod    = {hi_nx, lo_nx};
    prod_s  = neg_q ? -prod : prod;
    div_raw = op_q[1] ? hi_nx : lo_nx;
    div_res = neg_q ? -div_raw : div_raw;
    if (op_q[2])              fin_res = div_res;
    else if (op_q[1:0] == 2'b00) fin_res = prod_s[XLEN-1:0];
    else                      fin_res = prod_s[2*XLEN-1:XLEN];
  end

  // datapath: load on accept, iterate in CALC, publish result on entry to DONE
  always_ff @(posedge clk) begin
    if (reset) begin
      result_valid <= 1'b0;
      result       <= '0;
      op_q         <= '0;
      neg_q        <= 1'b0;
      opnd_q       <= '0;
      acc_hi       <= '0;
      acc_lo       <= '0;
      cnt          <= '0;
    end else begin
      result_valid <= (state_nx == DONE);
      if (accept) begin
        op_q   <= Funct3;
        neg_q  <= acc_neg;
        cnt    <= '0;
        acc_hi <= '0;
        opnd_q <= Funct3[2] ? mag_b : mag_a;
        acc_lo <= Funct3[2] ? mag_a : mag_b;
        if (spec) result <= spec_res;
      end else if (state == CALC && !flush) begin
        acc_hi <= hi_nx;
        acc_lo <= lo_nx;
        cnt    <= cnt + 1'b1;
        if (cnt == LAST) result <= fin_res;
      end
    end
  end

endmodule
